// File: rtl/inputdata_unit.sv
// Operand entry unit: debounced push-button captures two switch operands,
// then hands them to the control unit through a ready/loaddata handshake.
module inputdata_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic             restart,
    input  logic [WIDTH-1:0] switches,
    input  logic             loaddata,
    output logic             inputdata_ready,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic [1:0]       state_code
);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        READY = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic             press_c;
    logic [WIDTH-1:0] operand_a_next;
    logic [WIDTH-1:0] operand_b_next;
    logic             ready_next;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= enter;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign press_c = sync_2 & ~sync_prev;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= GET_A;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; restart wins over press and loaddata
    always_comb begin
        state_next = state;
        if (restart) begin
            state_next = GET_A;
        end else begin
            case (state)
                GET_A:   if (press_c)  state_next = GET_B;
                GET_B:   if (press_c)  state_next = READY;
                READY:   if (loaddata) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = GET_A;
            endcase
        end
    end

    // Output logic: operands load only on capture edges, ready mirrors READY
    always_comb begin
        operand_a_next = operand_a;
        operand_b_next = operand_b;
        ready_next     = (state_next == READY);
        if (!restart && press_c) begin
            if (state == GET_A) operand_a_next = switches;
            if (state == GET_B) operand_b_next = switches;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            operand_a       <= '0;
            operand_b       <= '0;
            inputdata_ready <= 1'b0;
        end else begin
            operand_a       <= operand_a_next;
            operand_b       <= operand_b_next;
            inputdata_ready <= ready_next;
        end
    end

    assign state_code = state;

endmodule

// File: tb/tb_inputdata_unit.sv
// Bench for inputdata_unit: directed scenarios plus randomized traffic,
// checked every cycle against a sample-history reference model.
module tb_inputdata_unit;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enter;
    logic             restart;
    logic [WIDTH-1:0] switches;
    logic             loaddata;
    logic             inputdata_ready;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [1:0]       state_code;

    int errors = 0;
    int checks = 0;

    inputdata_unit #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .enter           (enter),
        .restart         (restart),
        .switches        (switches),
        .loaddata        (loaddata),
        .inputdata_ready (inputdata_ready),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .state_code      (state_code)
    );

    always #5 clk = ~clk;

    // Reference: m_hist[i] is enter as seen i+1 edges ago; a press is
    // "seen high two edges ago, low three edges ago".
    logic [2:0]       m_hist;
    int               m_state;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] m_b;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hist  <= '0;
            m_state <= 0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            m_hist <= {m_hist[1:0], enter};
            if (restart) begin
                m_state <= 0;
            end else if (m_state == 0 && m_hist[1] && !m_hist[2]) begin
                m_a     <= switches;
                m_state <= 1;
            end else if (m_state == 1 && m_hist[1] && !m_hist[2]) begin
                m_b     <= switches;
                m_state <= 2;
            end else if (m_state == 2 && loaddata) begin
                m_state <= 3;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        #1;
        chk("model_state", 32'(state_code), 32'(m_state));
        chk("model_ready", 32'(inputdata_ready), 32'(m_state == 2));
        chk("model_a", 32'(operand_a), 32'(m_a));
        chk("model_b", 32'(operand_b), 32'(m_b));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [WIDTH-1:0] v);
        switches = v;
        enter    = 1'b1;
        cyc(4);
        enter    = 1'b0;
        cyc(3);
    endtask

    initial begin
        reset = 1'b0; enter = 1'b0; restart = 1'b0; switches = '0; loaddata = 1'b0;
        cyc(3); #1;
        chk("rst_state", 32'(state_code), 32'h0);
        chk("rst_ready", 32'(inputdata_ready), 32'h0);
        chk("rst_a", 32'(operand_a), 32'h0);
        chk("rst_b", 32'(operand_b), 32'h0);
        cyc(1);
        reset = 1'b1;
        cyc(2);

        // Two operands; READY three edges after the second press
        press(8'h12);
        switches = 8'h34; enter = 1'b1;
        cyc(2); #1;
        chk("pre_ready_state", 32'(state_code), 32'h1);
        cyc(1); #1;
        chk("ready_state", 32'(state_code), 32'h2);
        chk("ready_flag", 32'(inputdata_ready), 32'h1);
        chk("ready_a", 32'(operand_a), 32'h12);
        chk("ready_b", 32'(operand_b), 32'h34);
        cyc(1); enter = 1'b0; cyc(3);

        // Hold in READY, then single loaddata pulse
        cyc(10); #1;
        chk("hold_ready", 32'(inputdata_ready), 32'h1);
        cyc(1); loaddata = 1'b1;
        cyc(1); loaddata = 1'b0; #1;
        chk("done_state", 32'(state_code), 32'h3);
        chk("done_ready", 32'(inputdata_ready), 32'h0);

        // Press in DONE ignored
        press(8'hFF); #1;
        chk("done_press_a", 32'(operand_a), 32'h12);
        chk("done_press_b", 32'(operand_b), 32'h34);
        chk("done_press_state", 32'(state_code), 32'h3);

        // Restart, then loaddata in GET_A has no effect
        cyc(1); restart = 1'b1; cyc(1); restart = 1'b0;
        loaddata = 1'b1; cyc(2); loaddata = 1'b0; #1;
        chk("geta_load_state", 32'(state_code), 32'h0);

        // Held enter gives exactly one capture
        cyc(1); switches = 8'hAA; enter = 1'b1;
        cyc(20); switches = 8'h55; cyc(10); #1;
        chk("held_a", 32'(operand_a), 32'hAA);
        chk("held_state", 32'(state_code), 32'h1);
        cyc(1); enter = 1'b0; cyc(3);

        // Press in READY ignored; restart+loaddata together go to GET_A
        press(8'h3C);
        press(8'hFF); #1;
        chk("ready_press_a", 32'(operand_a), 32'hAA);
        chk("ready_press_b", 32'(operand_b), 32'h3C);
        chk("ready_press_state", 32'(state_code), 32'h2);
        cyc(1); restart = 1'b1; loaddata = 1'b1;
        cyc(1); restart = 1'b0; loaddata = 1'b0; #1;
        chk("restart_state", 32'(state_code), 32'h0);
        chk("restart_ready", 32'(inputdata_ready), 32'h0);
        chk("restart_a", 32'(operand_a), 32'hAA);
        chk("restart_b", 32'(operand_b), 32'h3C);

        // Asynchronous reset in GET_B clears outputs before the next edge
        cyc(1);
        press(8'h77);
        cyc(1); #2; reset = 1'b0; #1;
        chk("async_state", 32'(state_code), 32'h0);
        chk("async_a", 32'(operand_a), 32'h0);
        chk("async_b", 32'(operand_b), 32'h0);
        cyc(2); reset = 1'b1; cyc(1);
        press(8'h99); #1;
        chk("post_rst_a", 32'(operand_a), 32'h99);
        chk("post_rst_state", 32'(state_code), 32'h1);

        // enter held high across reset release yields one press
        cyc(1); switches = 8'h5A; enter = 1'b1; reset = 1'b0;
        cyc(2); reset = 1'b1;
        cyc(8); #1;
        chk("held_rst_a", 32'(operand_a), 32'h5A);
        chk("held_rst_state", 32'(state_code), 32'h1);
        cyc(1); enter = 1'b0; cyc(3);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) enter = ~enter;
            restart  = ($urandom_range(24) == 0);
            loaddata = ($urandom_range(3) == 0);
            switches = WIDTH'($urandom);
            reset    = ($urandom_range(250) != 0);
        end
        @(negedge clk);
        reset = 1'b1; enter = 1'b0; restart = 1'b0; loaddata = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
